// File: rtl/rm_ihpsg13_2p_march_bist.sv
// rtl/rm_ihpsg13_2p_march_bist.sv - March C- BIST engine for a two-port (A write / B read) SRAM macro.
// One memory op per RUN cycle; read data is checked RD_LAT cycles after issue.
module rm_ihpsg13_2p_march_bist #(
  parameter int DW     = 16,
  parameter int AW     = 9,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          STOP_ON_FAIL,
  input  logic [DW-1:0] BG,
  output logic          BIST_EN,
  output logic          A_BIST_MEN,
  output logic          A_BIST_WEN,
  output logic [AW-1:0] A_BIST_ADDR,
  output logic [DW-1:0] A_BIST_DIN,
  output logic [DW-1:0] A_BIST_BM,
  output logic          B_BIST_MEN,
  output logic          B_BIST_REN,
  output logic [AW-1:0] B_BIST_ADDR,
  input  logic [DW-1:0] B_DOUT,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic [15:0]   FAIL_CNT,
  output logic [AW-1:0] FAIL_ADDR,
  output logic [2:0]    FAIL_ELEM
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] ADDR_MAX   = '1;
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_ph_q, wr_ph_d;
  logic          stop_q, stop_d;
  logic [DW-1:0] bg_q, bg_d;
  logic [1:0]    drain_q, drain_d;
  logic          fail_q, fail_d;
  logic [15:0]   fail_cnt_q, fail_cnt_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]    fail_elem_q, fail_elem_d;

  logic          pv_q    [RD_LAT];
  logic          pv_d    [RD_LAT];
  logic [DW-1:0] pexp_q  [RD_LAT];
  logic [DW-1:0] pexp_d  [RD_LAT];
  logic [AW-1:0] paddr_q [RD_LAT];
  logic [AW-1:0] paddr_d [RD_LAT];
  logic [2:0]    pelem_q [RD_LAT];
  logic [2:0]    pelem_d [RD_LAT];

  logic run, busy, rw_elem, is_read, down, inv_w, exp_inv, last_addr;
  logic miscmp, abort;

  always_comb begin
    run       = (state_q == S_RUN);
    busy      = run || (state_q == S_DRAIN);
    rw_elem   = (elem_q != 3'd0) && (elem_q != 3'd5);
    is_read   = (elem_q == 3'd5) || (rw_elem && !wr_ph_q);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    inv_w     = (elem_q == 3'd1) || (elem_q == 3'd3);
    exp_inv   = (elem_q == 3'd2) || (elem_q == 3'd4);
    last_addr = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    miscmp    = busy && pv_q[RD_LAT-1] && (B_DOUT != pexp_q[RD_LAT-1]);
    abort     = miscmp && stop_q;
  end

  // Compare pipeline: carries expected data, address and element alongside each read.
  always_comb begin
    pv_d[0]    = run && is_read && !abort;
    pexp_d[0]  = exp_inv ? ~bg_q : bg_q;
    paddr_d[0] = addr_q;
    pelem_d[0] = elem_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i]    = pv_q[i-1] && !abort;
      pexp_d[i]  = pexp_q[i-1];
      paddr_d[i] = paddr_q[i-1];
      pelem_d[i] = pelem_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    wr_ph_d     = wr_ph_q;
    stop_d      = stop_q;
    bg_d        = bg_q;
    drain_d     = drain_q;
    fail_d      = fail_q;
    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          wr_ph_d     = 1'b0;
          stop_d      = STOP_ON_FAIL;
          bg_d        = BG;
          fail_d      = 1'b0;
          fail_cnt_d  = 16'h0000;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (rw_elem && !wr_ph_q) begin
          wr_ph_d = 1'b1;
        end else begin
          wr_ph_d = 1'b0;
          if (!last_addr) begin
            addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end else if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
            drain_d = 2'd0;
          end else begin
            // Next element is M3 or M4 when leaving M2 or M3: those walk downward.
            elem_d = elem_q + 3'd1;
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
          end
        end
      end
      S_DRAIN: begin
        if (abort || (drain_q == DRAIN_LAST)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (miscmp) begin
      if (fail_cnt_q != 16'hFFFF) begin
        fail_cnt_d = fail_cnt_q + 16'd1;
      end
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = paddr_q[RD_LAT-1];
        fail_elem_d = pelem_q[RD_LAT-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      wr_ph_q     <= 1'b0;
      stop_q      <= 1'b0;
      bg_q        <= '0;
      drain_q     <= 2'd0;
      fail_q      <= 1'b0;
      fail_cnt_q  <= 16'h0000;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i]    <= 1'b0;
        pexp_q[i]  <= '0;
        paddr_q[i] <= '0;
        pelem_q[i] <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      wr_ph_q     <= wr_ph_d;
      stop_q      <= stop_d;
      bg_q        <= bg_d;
      drain_q     <= drain_d;
      fail_q      <= fail_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i]    <= pv_d[i];
        pexp_q[i]  <= pexp_d[i];
        paddr_q[i] <= paddr_d[i];
        pelem_q[i] <= pelem_d[i];
      end
    end
  end

  always_comb begin
    BIST_EN     = busy;
    BUSY        = busy;
    DONE        = (state_q == S_DONE);
    A_BIST_MEN  = run && !is_read;
    A_BIST_WEN  = run && !is_read;
    A_BIST_ADDR = addr_q;
    A_BIST_DIN  = (run && !is_read) ? (inv_w ? ~bg_q : bg_q) : '0;
    A_BIST_BM   = '1;
    B_BIST_MEN  = run && is_read;
    B_BIST_REN  = run && is_read;
    B_BIST_ADDR = addr_q;
    FAIL        = fail_q;
    FAIL_CNT    = fail_cnt_q;
    FAIL_ADDR   = fail_addr_q;
    FAIL_ELEM   = fail_elem_q;
  end

endmodule

// File: doc/rm_ihpsg13_2p_march_bist.md
RM_IHPSG13_2P_MARCH_BIST -- requirements
Module: rm_ihpsg13_2p_march_bist

Interface
REQ-001 Parameter: DW, 16, data width in bits (1..64).
REQ-002 Parameter: AW, 9, address width; memory depth D = 2^AW.
REQ-003 Parameter: RD_LAT, 1, B-port read latency in cycles, from read issue to B_DOUT valid (1..3).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports:
- CLK  in  1  sole clock; all outputs change on its rising edge only.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request to begin a test; sampled only in IDLE or DONE.
- STOP_ON_FAIL  in  1  abort on first miscompare; sampled at START.
- BG  in  DW  background pattern; "0" data = BG, "1" data = ~BG; sampled at START.
- BIST_EN  out  1  high while BUSY; drives A_BIST_EN/B_BIST_EN of the macro.
- A_BIST_MEN, A_BIST_WEN  out  1 each  write-port enables.
- A_BIST_ADDR  out  AW  write address.
- A_BIST_DIN  out  DW  write data.
- A_BIST_BM  out  DW  write mask; constant all-ones.
- B_BIST_MEN, B_BIST_REN  out  1 each  read-port enables.
- B_BIST_ADDR  out  AW  read address.
- B_DOUT  in  DW  macro read data.
- BUSY, DONE, FAIL  out  1 each  status.
- FAIL_CNT  out  16  saturating miscompare count.
- FAIL_ADDR  out  AW  address of the first miscompare.
- FAIL_ELEM  out  3  March element (0..5) of the first miscompare.

Function
REQ-006 The block SHALL run March C-: M0 any-order w0; M1 up (r0,w1); M2 up (r1,w0); M3 down (r0,w1); M4 down (r1,w0); M5 any-order r0. Any-order elements SHALL use up order.
- Up order = 0..D-1; down order = D-1..0.
REQ-007 States SHALL be IDLE, RUN, DRAIN, DONE:
- IDLE/DONE + START -> RUN.
- RUN, after the last M5 op -> DRAIN.
- DRAIN, after RD_LAT cycles -> DONE.
- RUN/DRAIN with an abort -> DONE.
REQ-008 Exactly one operation SHALL be issued per RUN cycle:
- Within (r,w) elements, the read at address x is issued first and the write to x in the following cycle.
- Total ops SHALL be 10*D.
- The first op SHALL be issued in the cycle after START is sampled.
REQ-009 Write op outputs: A_BIST_MEN=1, A_BIST_WEN=1, A_BIST_ADDR=x, A_BIST_DIN=pattern; all B enables 0.
REQ-010 Read op outputs: B_BIST_MEN=1, B_BIST_REN=1, B_BIST_ADDR=x; all A enables 0.
REQ-011 Outside RUN, all MEN/WEN/REN outputs SHALL be 0.
REQ-012 Expected data, address and element SHALL be pipelined RD_LAT stages. B_DOUT SHALL be compared exactly RD_LAT cycles after each read issue.
REQ-013 On a miscompare:
- FAIL_CNT SHALL increment, saturating at 16'hFFFF.
- On the first miscompare only, FAIL_ADDR and FAIL_ELEM SHALL be captured and FAIL set.
- FAIL SHALL stay set until the next START or reset.
REQ-014 With STOP_ON_FAIL=1, the cycle after the first miscompare SHALL be in DONE. No further ops are issued and in-flight compares are discarded.
REQ-015 BUSY SHALL be 1 in RUN and DRAIN. DONE SHALL be 1 only in the DONE state.
REQ-016 START SHALL be ignored while BUSY.
REQ-017 START in DONE SHALL clear FAIL, FAIL_CNT, FAIL_ADDR and FAIL_ELEM in the same edge that enters RUN.
REQ-018 The address counter SHALL wrap only at element boundaries. At each boundary it SHALL reload 0 (up) or D-1 (down) with no idle cycle between elements.

Reset
REQ-019 RST_N low SHALL immediately force:
- state IDLE;
- all outputs 0, except A_BIST_BM = all-ones;
- the compare pipeline cleared.
REQ-020 Reset asserted mid-RUN SHALL abort with no further memory op, including the op of the current cycle once outputs settle.
REQ-021 After RST_N rises, the block SHALL wait for START.

Verification
REQ-022 The bench SHALL cover these directed scenarios with AW=4, DW=8, RD_LAT=1 and a fault-free 2P memory model:
- REQ-022a Fault-free run: START at cycle 0, BG=8'h00 -> 160 ops in cycles 1..160; DONE=1 from cycle 162; FAIL=0; FAIL_CNT=0.
- REQ-022b Stuck-at-1: bit 3 of address 5 stuck at 1, BG=8'h00, STOP_ON_FAIL=0 -> FAIL=1, FAIL_ADDR=5, FAIL_ELEM=1, FAIL_CNT=3.
- REQ-022c Stop on fail: same fault with STOP_ON_FAIL=1 -> DONE=1 two cycles after the M1 read of address 5; FAIL_CNT=1; no op issued after the miscompare.
- REQ-022d Inverted background and restart: BG=8'hA5, fault-free -> every M0 write carries 8'hA5 and every M1 write 8'h5A; START during RUN ignored; a second START from DONE clears the status and reruns 160 ops.
- REQ-022e Reset mid-run: RST_N low at cycle 70 -> all enables 0 in the same cycle; after release, BUSY=0 and DONE=0 until START.
- REQ-022f Saturation: force FAIL_CNT to 16'hFFFE, then inject two miscompares -> FAIL_CNT reads 16'hFFFF.
